// File: rtl/bmem_burst_ctrl.sv
// bmem_burst_ctrl: burst-memory slave for the CPU bmem_* port.
// Converts 4-beat 256-bit line reads/writes into single-beat 64-bit accesses
// on a synchronous SRAM, returning bmem_resp per beat after LATENCY cycles.
// The RAM-side strobes are decoded from the registered state so that a read
// issued in the last WAIT cycle returns its data in the first response cycle.
module bmem_burst_ctrl #(
  parameter int LATENCY    = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bmem_address,
  input  logic                  bmem_read,
  input  logic                  bmem_write,
  input  logic [63:0]           bmem_wdata,
  output logic [63:0]           bmem_rdata,
  output logic                  bmem_resp,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [63:0]           ram_wdata,
  input  logic [63:0]           ram_rdata,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-3:0] line;
  logic                  op_wr;
  logic [7:0]            cnt;
  logic [1:0]            beat;
  logic [63:0]           rdata_q;
  logic                  resp_q;
  logic [1:0]            beat_nxt;

  assign beat_nxt = 2'(beat + 2'd1);

  // Burst sequencing FSM: request capture, latency countdown, beat counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      line    <= '0;
      op_wr   <= 1'b0;
      cnt     <= '0;
      beat    <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bmem_read || bmem_write) begin
            line  <= bmem_address[ADDR_WIDTH+2:5];
            // A conflicting read+write request is serviced as a read.
            op_wr <= bmem_write & ~bmem_read;
            if (bmem_read && bmem_write) err <= 1'b1;
            cnt   <= 8'(LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            beat   <= 2'd0;
            resp_q <= 1'b1;
            state  <= op_wr ? WBURST : RBURST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RBURST: begin
          rdata_q <= ram_rdata;
          beat    <= beat_nxt;
          if (beat == 2'd3) begin
            resp_q <= 1'b0;
            state  <= GAP;
          end
        end
        WBURST: begin
          beat <= beat_nxt;
          if (beat == 2'd3) begin
            resp_q <= 1'b0;
            state  <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM strobes and read-data steering decoded from the current state.
  always_comb begin
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    bmem_rdata = rdata_q;
    case (state)
      WAIT: begin
        // First beat is fetched in the last wait cycle so it lands with resp.
        if (cnt == 8'd0 && !op_wr) begin
          ram_re   = 1'b1;
          ram_addr = {line, 2'd0};
        end
      end
      RBURST: begin
        bmem_rdata = ram_rdata;
        if (beat != 2'd3) begin
          ram_re   = 1'b1;
          ram_addr = {line, beat_nxt};
        end
      end
      WBURST: begin
        ram_we    = 1'b1;
        ram_addr  = {line, beat};
        ram_wdata = bmem_wdata;
      end
      default: ;
    endcase
  end

  assign bmem_resp = resp_q;

endmodule
